// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel blocks.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACTIVE,
        ST_STROBE,
        ST_GAP
    } periph_state_t;

    localparam logic DIR_DEV2MEM = 1'b0;
    localparam logic DIR_MEM2DEV = 1'b1;

    // Maps between an active-high internal level and a pin of configurable polarity.
    function automatic logic apply_polarity(input logic level, input logic active_low);
        return level ^ active_low;
    endfunction

endpackage

// File: rtl/dma_byte_fifo.sv
// Byte FIFO with power-of-two depth; a push into a full FIFO is accepted only alongside a pop.
module dma_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [7:0]                   push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   head
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_periph_agent.sv
// Peripheral endpoint of the 8237A DREQ/DACK handshake: one channel, one byte per I/O strobe.
module dma_periph_agent
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter bit          DREQ_ACTIVE_LOW = 1'b0,
    parameter bit          DACK_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       dir,
    input  logic       single_mode,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic       EOP_N,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       snk_valid,
    output logic [7:0] snk_data,
    input  logic       snk_ready,
    input  logic       tc_clr,
    output logic       tc,
    output logic       err
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    periph_state_t state, state_next;

    logic          ack, ior_q, iow_q, strobe_n, bus_rise;
    logic          bus_pop, bus_push, src_push, snk_pop, fifo_push, fifo_pop;
    logic          underrun, overrun, eop_now, ready, ready_after, req_next;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [CW:0]   cnt_after;
    logic [7:0]    head, db_q, fifo_wdata;

    dma_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    assign ack      = apply_polarity(DACK, DACK_ACTIVE_LOW);
    assign strobe_n = (dir == DIR_MEM2DEV) ? IOW_N : IOR_N;
    // Data moves on any acknowledged strobe rising edge, so under/overrun is caught even when no request is pending.
    assign bus_rise = ack && ((dir == DIR_MEM2DEV) ? (!iow_q && IOW_N) : (!ior_q && IOR_N));
    assign bus_pop  = (dir == DIR_DEV2MEM) && bus_rise && !empty;
    assign underrun = (dir == DIR_DEV2MEM) && bus_rise && empty;
    assign bus_push = (dir == DIR_MEM2DEV) && bus_rise && !full;
    assign overrun  = (dir == DIR_MEM2DEV) && bus_rise && full;
    assign eop_now  = ack && !EOP_N;

    assign src_ready  = !RESET && !full && (dir == DIR_DEV2MEM);
    assign snk_valid  = !RESET && !empty && (dir == DIR_MEM2DEV);
    assign snk_data   = head;
    assign src_push   = src_valid && src_ready;
    assign snk_pop    = snk_valid && snk_ready;
    assign fifo_push  = bus_push || src_push;
    assign fifo_pop   = bus_pop || snk_pop;
    assign fifo_wdata = (dir == DIR_MEM2DEV) ? db_q : src_data;

    assign ready       = (dir == DIR_MEM2DEV) ? !full : !empty;
    assign cnt_after   = {1'b0, count} + {{CW{1'b0}}, fifo_push} - {{CW{1'b0}}, fifo_pop};
    assign ready_after = (dir == DIR_MEM2DEV) ? (cnt_after != (CW+1)'(DEPTH)) : (cnt_after != '0);

    assign DB_OE  = !RESET && ack && !IOR_N && (dir == DIR_DEV2MEM);
    assign DB_OUT = empty ? 8'h00 : head;

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (ready && !(tc && !tc_clr)) state_next = ST_REQ;
            ST_REQ:    if (ack) state_next = ST_ACTIVE;
                       else if (!ready) state_next = ST_IDLE;
            ST_ACTIVE: if (!ack) state_next = ST_IDLE;
                       else if (!strobe_n) state_next = ST_STROBE;
            ST_STROBE: if (!ack) state_next = ST_IDLE;
                       else if (bus_rise) begin
                           if (single_mode || !ready_after || tc || eop_now) state_next = ST_GAP;
                           else state_next = ST_ACTIVE;
                       end
            ST_GAP:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (tc_clr && state != ST_IDLE) state_next = ST_IDLE;
        req_next = (state_next == ST_REQ) || (state_next == ST_ACTIVE) || (state_next == ST_STROBE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            DREQ  <= DREQ_ACTIVE_LOW;
            ior_q <= 1'b1;
            iow_q <= 1'b1;
            db_q  <= '0;
            tc    <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            DREQ  <= apply_polarity(req_next, DREQ_ACTIVE_LOW);
            ior_q <= IOR_N;
            iow_q <= IOW_N;
            if (!IOW_N) db_q <= DB_IN;
            if (tc_clr) begin
                tc  <= 1'b0;
                err <= 1'b0;
            end else begin
                tc  <= tc | eop_now;
                err <= err | underrun | overrun;
            end
        end
    end

endmodule

// File: tb/tb_dma_periph_agent.sv
// Randomized self-checking bench for dma_periph_agent against a queue-based byte model.
module tb_dma_periph_agent;
    localparam int DEPTH    = 4;
    localparam logic DACK_ON  = 1'b0;
    localparam logic DACK_OFF = 1'b1;

    logic       clk = 1'b0;
    logic       RESET, dir, single_mode, DREQ, DACK, IOR_N, IOW_N, EOP_N;
    logic [7:0] DB_IN, DB_OUT, src_data, snk_data;
    logic       DB_OE, src_valid, src_ready, snk_valid, snk_ready, tc_clr, tc, err;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    logic       m_err, m_tc;

    always #5 clk = ~clk;

    dma_periph_agent #(.DEPTH(DEPTH), .DREQ_ACTIVE_LOW(1'b0), .DACK_ACTIVE_LOW(1'b1)) dut (
        .CLK(clk), .RESET(RESET), .dir(dir), .single_mode(single_mode), .DREQ(DREQ),
        .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN),
        .DB_OUT(DB_OUT), .DB_OE(DB_OE), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .snk_valid(snk_valid), .snk_data(snk_data),
        .snk_ready(snk_ready), .tc_clr(tc_clr), .tc(tc), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic d);
        RESET = 1'b1; dir = d; single_mode = 1'b0; DACK = DACK_OFF;
        IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; DB_IN = '0;
        src_valid = 1'b0; src_data = '0; snk_ready = 1'b0; tc_clr = 1'b0;
        step(); step();
        RESET = 1'b0;
        q.delete(); m_err = 1'b0; m_tc = 1'b0;
        step();
    endtask

    task automatic push_src(input logic [7:0] b);
        src_valid = 1'b1; src_data = b;
        step();
        src_valid = 1'b0;
        q.push_back(b);
    endtask

    task automatic rd_pulse(input string tag);
        logic [7:0] exp;
        exp = (q.size() > 0) ? q[0] : 8'h00;
        IOR_N = 1'b0;
        #1;
        check({tag, "_oe"}, DB_OE, 1);
        check({tag, "_dout"}, DB_OUT, exp);
        step();
        IOR_N = 1'b1;
        step();
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1'b1;
        check({tag, "_err"}, err, m_err);
    endtask

    task automatic wr_pulse(input string tag, input logic [7:0] b);
        DB_IN = b; IOW_N = 1'b0;
        step();
        IOW_N = 1'b1; DB_IN = 8'($urandom);
        step();
        if (q.size() < DEPTH) q.push_back(b);
        else m_err = 1'b1;
        check({tag, "_err"}, err, m_err);
    endtask

    task automatic drain_snk(input string tag);
        while (q.size() > 0) begin
            check({tag, "_valid"}, snk_valid, 1);
            check({tag, "_data"}, snk_data, q[0]);
            snk_ready = 1'b1;
            step();
            snk_ready = 1'b0;
            void'(q.pop_front());
        end
        check({tag, "_empty"}, snk_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        int         n, waited;

        // Reset state
        RESET = 1'b1; dir = 1'b0; single_mode = 1'b0; DACK = DACK_OFF;
        IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; DB_IN = '0;
        src_valid = 1'b0; src_data = '0; snk_ready = 1'b0; tc_clr = 1'b0;
        step(); step();
        check("rst_dreq", DREQ, 0);
        check("rst_oe", DB_OE, 0);
        check("rst_dout", DB_OUT, 0);
        check("rst_tc", tc, 0);
        check("rst_err", err, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_snk_valid", snk_valid, 0);

        // Demand mode, device to memory
        do_reset(1'b0);
        push_src(8'hA1);
        check("dem_dreq_early", DREQ, 0);
        push_src(8'hA2);
        check("dem_dreq_on", DREQ, 1);
        push_src(8'hA3);
        DACK = DACK_ON;
        step();
        for (int k = 0; k < 3; k++) begin
            rd_pulse("dem");
            check("dem_dreq_after", DREQ, (k < 2) ? 1 : 0);
        end
        DACK = DACK_OFF;

        // Single mode, memory to device
        do_reset(1'b1);
        single_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waited = 0;
            while (DREQ !== 1'b1 && waited < 8) begin step(); waited++; end
            check("sgl_dreq_wait", DREQ, 1);
            DACK = DACK_ON;
            step();
            wr_pulse("sgl", 8'h10 + 8'(k));
            check("sgl_gap", DREQ, 0);
            DACK = DACK_OFF;
            step();
            check("sgl_gap2", DREQ, 0);
        end
        drain_snk("sgl_snk");

        // EOP during the second byte, then tc_clr
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) push_src(8'($urandom));
        step(); step();
        DACK = DACK_ON;
        step();
        rd_pulse("eop_b1");
        check("eop_dreq_b1", DREQ, 1);
        EOP_N = 1'b0;
        rd_pulse("eop_b2");
        EOP_N = 1'b1;
        m_tc = 1'b1;
        check("eop_tc", tc, m_tc);
        check("eop_dreq_b2", DREQ, 0);
        DACK = DACK_OFF;
        repeat (4) step();
        check("eop_holdoff", DREQ, 0);
        check("eop_tc_held", tc, m_tc);
        tc_clr = 1'b1;
        step();
        tc_clr = 1'b0;
        m_tc = 1'b0;
        check("eop_tc_clr", tc, m_tc);
        check("eop_rereq", DREQ, 1);
        DACK = DACK_ON;
        step();
        rd_pulse("eop_b3");
        check("eop_dreq_end", DREQ, 0);
        DACK = DACK_OFF;

        // Underrun
        do_reset(1'b0);
        DACK = DACK_ON;
        step();
        rd_pulse("udr");
        DACK = DACK_OFF;
        step(); step();
        check("udr_no_req", DREQ, 0);
        check("udr_dout", DB_OUT, 0);
        tc_clr = 1'b1;
        step();
        tc_clr = 1'b0;
        m_err = 1'b0;
        check("udr_err_clr", err, m_err);

        // Simultaneous local push and bus pop, then fill to DEPTH
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) push_src(8'($urandom));
        step(); step();
        DACK = DACK_ON;
        step();
        b = q[0];
        IOR_N = 1'b0;
        #1;
        check("sim_dout", DB_OUT, b);
        step();
        IOR_N = 1'b1; src_valid = 1'b1; src_data = 8'($urandom);
        step();
        src_valid = 1'b0;
        void'(q.pop_front());
        q.push_back(src_data);
        check("sim_not_full", src_ready, 1);
        push_src(8'($urandom));
        check("sim_full", src_ready, 0);
        for (int k = 0; k < DEPTH; k++) begin
            rd_pulse("sim_drain");
            check("sim_dreq", DREQ, (k < DEPTH - 1) ? 1 : 0);
        end
        DACK = DACK_OFF;

        // Overrun on a fifth IOW_N into a full buffer
        do_reset(1'b1);
        DACK = DACK_ON;
        step();
        for (int k = 0; k < DEPTH + 1; k++) wr_pulse("ovr", 8'($urandom));
        check("ovr_err", err, 1);
        DACK = DACK_OFF;
        step();
        drain_snk("ovr_snk");

        // RESET while in STROBE
        do_reset(1'b0);
        push_src(8'($urandom));
        push_src(8'($urandom));
        step(); step();
        DACK = DACK_ON;
        step();
        IOR_N = 1'b0;
        step();
        RESET = 1'b1;
        step();
        check("rms_dreq", DREQ, 0);
        check("rms_oe", DB_OE, 0);
        check("rms_src_ready", src_ready, 0);
        RESET = 1'b0; IOR_N = 1'b1; DACK = DACK_OFF;
        q.delete(); m_err = 1'b0;
        step();
        check("rms_empty_rdy", src_ready, 1);
        check("rms_dout", DB_OUT, 0);
        step(); step();
        check("rms_no_req", DREQ, 0);

        // Randomized demand-mode bursts
        do_reset(1'b0);
        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(1, DEPTH));
            for (int k = 0; k < n; k++) push_src(8'($urandom));
            step(); step();
            check("rnd_dreq_on", DREQ, 1);
            DACK = DACK_ON;
            step();
            for (int k = 0; k < n; k++) begin
                rd_pulse("rnd");
                check("rnd_dreq", DREQ, (k < n - 1) ? 1 : 0);
            end
            DACK = DACK_OFF;
            repeat (int'($urandom_range(1, 3))) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_periph_agent.md
# dma_periph_agent

Peripheral-side endpoint of the 8237A DREQ/DACK handshake for one DMA channel. Raises DREQ when its local byte buffer can source or sink a transfer, and waits for DACK. Exchanges one byte per IOR_N/IOW_N strobe and honours EOP_N. It is the device the priority/arbitration logic serves, and the bench-side stimulus agent for channel-level DMA tests.

## Interface
Parameters:
- DEPTH, 4: buffer depth in bytes, power of two, ≥2.
- DREQ_ACTIVE_LOW, 0: DREQ polarity. Matches command register bit 6.
- DACK_ACTIVE_LOW, 1: DACK polarity. Matches command register bit 7 = 0.

Ports:
- CLK in 1: clock.
- RESET in 1: synchronous, active-high reset.
- dir in 1: transfer direction.
  - 0: device→memory; device drives data on IOR_N.
  - 1: memory→device; device captures data on IOW_N.
- single_mode in 1: request mode.
  - 1: single mode, re-request after each byte.
  - 0: demand mode.
- DREQ out 1: request to the DMA controller, polarity per DREQ_ACTIVE_LOW.
- DACK in 1: acknowledge, polarity per DACK_ACTIVE_LOW.
- IOR_N in 1: I/O read strobe, active low.
- IOW_N in 1: I/O write strobe, active low.
- EOP_N in 1: terminal count / end of process, active low.
- DB_IN in 8: data bus input.
- DB_OUT out 8: data bus output.
- DB_OE out 1: data bus output enable.
- src_valid in 1, src_data in 8, src_ready out 1: local producer push (dir=0).
- snk_valid out 1, snk_data out 8, snk_ready in 1: local consumer pop (dir=1).
- tc_clr in 1: clears the terminal-count latch.
- tc out 1: terminal count reached.
- err out 1: sticky underrun/overrun flag, cleared by tc_clr.

## Operation
- Internal active-high signals: ack = DACK XOR DACK_ACTIVE_LOW; req drives DREQ = req XOR DREQ_ACTIVE_LOW.
- count: buffer occupancy, width $clog2(DEPTH+1).
- ready condition:
  - dir=0: count≠0.
  - dir=1: count≠DEPTH.
- FSM states: IDLE, REQ, ACTIVE, STROBE, GAP.
  - IDLE→REQ: ready && !tc.
  - REQ (req=1)→ACTIVE: ack.
  - REQ→IDLE: ready drops before ack.
  - ACTIVE (req=1)→STROBE: active strobe (IOR_N for dir=0, IOW_N for dir=1) sampled low.
  - ACTIVE→IDLE: ack drops.
  - STROBE→transfer: strobe rising edge (low last cycle, high now) completes the transfer.
    - To GAP if single_mode, ready lost, or EOP_N was sampled low during the acknowledged cycle.
    - Otherwise back to ACTIVE.
  - GAP (req=0, one cycle)→IDLE.
- dir=0 transfer:
  - DB_OE = ack && !IOR_N && dir==0, combinational.
  - DB_OUT = buffer head.
  - Pop on the IOR_N rising edge.
- dir=1 transfer:
  - DB_IN is registered every cycle IOW_N is low.
  - The last low-cycle value is pushed on the IOW_N rising edge.
- Underrun (IOR_N strobe with count=0): DB_OUT=8'h00, no pop, err←1.
- Overrun (IOW_N strobe with count=DEPTH): byte dropped, err←1.
- EOP_N sampled low while ack: tc←1. Takes effect after the current transfer completes.
  - Request is held off while tc=1.
  - tc_clr clears tc and err, and returns the FSM to IDLE.
- Local ports:
  - src_ready = (count<DEPTH) && dir==0.
  - snk_valid = (count≠0) && dir==1.
  - snk_data = buffer head.
- Simultaneous local push and bus pop (or bus push and local pop): count unchanged, both bytes handled.
- Buffer pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - DREQ inactive, i.e. DREQ_ACTIVE_LOW.
  - DB_OE=0, DB_OUT=0, tc=0, err=0.
  - src_ready=0 during reset, snk_valid=0, count=0, state IDLE.
- DREQ is registered. It asserts one cycle after ready is seen in IDLE.
- DREQ deasserts in the cycle after the qualifying strobe rising edge; it is low for at least the GAP cycle.
- Count updates one cycle after the push/pop edge.
- ack dropping mid-STROBE aborts: no transfer, state→IDLE.
- Changing dir outside IDLE is illegal.
- RESET mid-transfer discards buffer contents.

## Structure
- Shared package dma_pkg holds:
  - periph_state_t enum.
  - DIR_DEV2MEM/DIR_MEM2DEV constants.
  - Polarity helper function.
- The buffer is sub-module dma_byte_fifo (DEPTH parameter; push/pop/full/empty/count). The FSM lives in dma_periph_agent.

## Test plan
- Demand, dir=0: push 8'hA1,A2,A3; DACK active, three IOR_N pulses → DB_OUT A1,A2,A3 in order; DREQ drops the cycle after the third rising edge.
- Single, dir=1: three IOW_N pulses with DB_IN 8'h10,11,12 → DREQ low ≥1 cycle between bytes; snk_data 10,11,12.
- EOP_N low during the second byte → tc=1, DREQ stays inactive despite data; tc_clr → DREQ re-asserts next cycle.
- Underrun: IOR_N pulse with an empty buffer → DB_OUT=00, err=1, count stays 0.
- Fill to DEPTH=4 with a simultaneous src push and IOR_N pop → count stays 4, no data lost; fifth IOW_N (dir=1, full) → err=1.
- RESET asserted while in STROBE → next cycle DREQ inactive, DB_OE=0, count=0.
